// File: rtl/pc_select_block.sv
// rtl/pc_select_block.sv - program-counter register with next-PC select mux
// Picks the sequential or jump address and loads it into the PC when enabled.
module pc_select_block #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pcSrc,
  input  logic [WIDTH-1:0] nextInst,
  input  logic [WIDTH-1:0] jump,
  input  logic             pcWrite,
  output logic [WIDTH-1:0] pcNext,
  output logic [WIDTH-1:0] pcCur
);

  // Exposed unregistered so downstream logic can forward it in the same cycle.
  assign pcNext = pcSrc ? jump : nextInst;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcCur <= RESET_VECTOR;
    end else if (pcWrite) begin
      pcCur <= pcNext;
    end
  end

endmodule

// File: tb/tb_pc_select_block.sv
// tb/tb_pc_select_block.sv - self-checking bench for pc_select_block
// Scripted scenarios, a hand-computed vector table, then random stimulus against a model.
module tb_pc_select_block;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] RV = 16'h0000;

  logic             clock;
  logic             reset_n;
  logic             pcSrc;
  logic [WIDTH-1:0] nextInst;
  logic [WIDTH-1:0] jump;
  logic             pcWrite;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] pcCur;

  int checks   = 0;
  int failures = 0;

  pc_select_block #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .pcSrc    (pcSrc),
    .nextInst (nextInst),
    .jump     (jump),
    .pcWrite  (pcWrite),
    .pcNext   (pcNext),
    .pcCur    (pcCur)
  );

  // Period 20 ns, first rising edge at 20 ns.
  initial begin
    clock = 1'b1;
    forever #10 clock = ~clock;
  end

  typedef struct {
    logic             rstN;
    logic             src;
    logic             wr;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] jmp;
    logic [WIDTH-1:0] expNext;
    logic [WIDTH-1:0] expCur;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic w,
                       input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] j);
    reset_n  = r;
    pcSrc    = s;
    pcWrite  = w;
    nextInst = n;
    jump     = j;
  endtask

  initial begin
    logic [WIDTH-1:0] model;
    logic [WIDTH-1:0] held;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'hAAAA, 16'h0001, 16'h0001};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0001, 16'hAAAA, 16'hAAAA, 16'hAAAA};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h5555, 16'h1111, 16'h5555, 16'hAAAA};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h5555, 16'h1111, 16'h1111, 16'hAAAA};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h4321, 16'h4321, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h4321, 16'h4321, 16'h4321};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};

    // 1: reset at t=0, PC held at the reset vector through t=100.
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1 check("reset_immediate", pcCur, RV);
    #4 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("reset_hold", pcCur, RV);
    end

    // 2: sequential load of 42.
    drive(1'b1, 1'b0, 1'b1, 16'd42, 16'h0000);
    #1 check("seq_pcNext", pcNext, 16'd42);
    @(posedge clock); #1 check("seq_load", pcCur, 16'd42);
    @(posedge clock); #1 check("seq_stay", pcCur, 16'd42);

    // 3: jump to 24.
    jump = 16'd24; pcSrc = 1'b1;
    #1 check("jump_pcNext", pcNext, 16'd24);
    @(posedge clock); #1 check("jump_load", pcCur, 16'd24);

    // 4: write disabled, mux still follows inputs, PC holds.
    pcWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextInst = (i % 2) ? 16'hFFFF : 16'h1234;
      jump     = (i % 2) ? 16'h1234 : 16'hFFFF;
      pcSrc    = i[0];
      #1 check("hold_pcNext", pcNext, i[0] ? jump : nextInst);
      @(posedge clock); #1 check("hold_pcCur", pcCur, 16'd24);
    end

    // Unknown data with write disabled must not disturb the PC.
    nextInst = 'x; jump = 'x;
    @(posedge clock); #1 check("hold_x_data", pcCur, 16'd24);

    // 5: load all-ones, then async reset between edges.
    drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    @(posedge clock); #1 check("ones_load", pcCur, 16'hFFFF);
    #4 reset_n = 1'b0;
    #1 check("async_reset", pcCur, RV);
    @(posedge clock); #1 check("reset_beats_write", pcCur, RV);

    // 6: release with a jump to 0x8000 pending.
    pcSrc = 1'b1; jump = 16'h8000;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1 check("release_load", pcCur, 16'h8000);

    // Reset asserted exactly on a clock edge while a load is requested.
    jump = 16'h3C3C;
    @(posedge clock); reset_n = 1'b0;
    #1 check("reset_on_edge", pcCur, RV);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1 check("after_edge_reset", pcCur, 16'h3C3C);

    // Table-driven vectors: drive on falling edge, sample mux then register.
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      drive(vecs[i].rstN, vecs[i].src, vecs[i].wr, vecs[i].nxt, vecs[i].jmp);
      #1 check($sformatf("vec%0d_pcNext", i), pcNext, vecs[i].expNext);
      @(posedge clock); #1 check($sformatf("vec%0d_pcCur", i), pcCur, vecs[i].expCur);
    end

    // Randomized run against a reference model of the PC.
    model = pcCur;
    for (int i = 0; i < 300; i++) begin
      logic r, s, w;
      logic [WIDTH-1:0] n, j;
      @(negedge clock);
      r = ($urandom_range(0, 15) != 0);
      s = $urandom_range(0, 1);
      w = ($urandom_range(0, 3) != 0);
      n = $urandom;
      j = $urandom;
      if (($urandom_range(0, 9)) == 0) n = 16'hFFFF;
      drive(r, s, w, n, j);
      #1 check("rnd_pcNext", pcNext, s ? j : n);
      if (!r) begin
        model = RV;
        check("rnd_async", pcCur, RV);
      end
      held = model;
      @(posedge clock); #1;
      if (!r)      model = RV;
      else if (w)  model = s ? j : n;
      else         model = held;
      check("rnd_pcCur", pcCur, model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_select_block.md
Name: pc_select_block

Overview:
Program-counter register for the 16-bit datapath. Each cycle it selects the next PC from two candidates:
- the sequential address, computed by the fetch adder upstream
- the jump/branch target, computed by the control/ALU path

It loads the selected value into the PC register when write is enabled. The current PC drives instruction memory and the fetch adder.

Parameters:
- WIDTH, 16, bit width of the PC and both candidate address inputs.
- RESET_VECTOR, 16'h0000, value loaded into the PC while reset is asserted.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- pcSrc  input  1  next-PC select: 0 = nextInst, 1 = jump.
- nextInst  input  WIDTH  sequential next-instruction address.
- jump  input  WIDTH  jump/branch target address.
- pcWrite  input  1  PC load enable, active-high.
- pcNext  output  WIDTH  combinational selected next PC (mux output), for debug/forwarding.
- pcCur  output  WIDTH  registered current PC.

Behaviour:
Interface:
- One clock. Reset is asynchronous and active-low. Clock port is "clock", reset port is "reset_n".

Reset:
- reset_n = 0 forces pcCur = RESET_VECTOR immediately, without waiting for a clock edge.
- pcCur holds RESET_VECTOR for as long as reset_n is low, regardless of pcWrite or pcSrc.
- Release of reset_n is sampled synchronously. The first load can occur on the first rising edge at which reset_n is already high.

Next-PC mux (pcNext):
- Purely combinational: pcNext = pcSrc ? jump : nextInst.
- Tracks input changes within the same cycle. No latch is inferred.

Register update:
- On each rising clock edge with reset_n = 1:
  - if pcWrite = 1, pcCur <= pcNext;
  - else pcCur holds its value.
- Latency: one clock. A value presented before edge N appears on pcCur after edge N.
- No arithmetic is performed inside the block. Values pass through unmodified, full WIDTH, no wrap or saturation.
- All-ones inputs load as all-ones.

Unknown inputs:
- X/Z on pcSrc while pcWrite = 1 is a caller error. Simulation may propagate X.
- pcWrite = 0 must hold pcCur even if the data inputs are X.

Simultaneous events:
- A reset assertion coinciding with a clock edge wins; pcCur = RESET_VECTOR.
- pcSrc and the data inputs changing in the same cycle as pcWrite rises: the values present at the edge are loaded.

Mid-operation:
- Asserting reset_n low at any time returns pcCur to RESET_VECTOR.
- After release, normal loading resumes with no extra wait cycles.

Test Plan:
Clock period 20 ns, first rising edge at 20 ns.
1. reset_n pulsed low at t=0 with pcWrite=0, pcSrc=0, nextInst=0, jump=0 -> pcCur = 0x0000 immediately. pcCur stays 0x0000 through t=100 ns.
2. At t=100 ns set nextInst=42, pcWrite=1, pcSrc=0 -> pcNext = 42 immediately; pcCur = 42 after the next rising edge; pcCur remains 42 on later edges.
3. At t=200 ns set jump=24, pcSrc=1, pcWrite held at 1 -> pcNext = 24 immediately; pcCur = 24 after the next rising edge.
4. pcWrite=0 while toggling pcSrc and changing nextInst/jump (e.g. 0x1234 / 0xFFFF) -> pcCur holds its previous value (24); pcNext follows the mux.
5. pcWrite=1, pcSrc=0, nextInst=0xFFFF, then assert reset_n=0 between edges -> pcCur = 0xFFFF after the edge, then drops to 0x0000 asynchronously, before the next edge.
6. Release reset_n with pcWrite=1, pcSrc=1, jump=0x8000 -> pcCur = 0x8000 after the first rising edge following release.
